sb_config_ctrl: RTL and testbench

Configuration front-end for one CGRA tile switch box: decodes the global configuration bus, holds a shadow copy of the 32-bit switch-box configuration word, and drives the active `config_sb` word consumed by the switch-box mux logic (bits [11:10] select the `out_1_0` source: 0=in_0, 1=in_2, 2=in_3, 3=pe_output). Writes land in the shadow register. A global commit strobe copies the shadow register to the active register, so every tile switches routing on the same cycle. Readback is supported for debug.

---
 rtl/sb_config_ctrl.sv | 124 ++++++++++++
 tb/tb_sb_config_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sb_config_ctrl.sv
// sb_config_ctrl: configuration front-end for one CGRA tile switch box.
// Decodes the global configuration bus, holds a shadow copy of the switch-box
// configuration word and drives the active word on a global commit strobe.
// All outputs are registered; reset is synchronous and active-high.
module sb_config_ctrl #(
  parameter logic [15:0] TILE_ID    = 16'h0001,
  parameter logic [7:0]  SB_FEATURE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] config_addr,
  input  logic [31:0] config_data,
  input  logic [3:0]  config_byte_en,
  input  logic        config_write,
  input  logic        config_read,
  input  logic        config_commit,
  output logic [31:0] config_sb,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        commit_pending
);

  // Register indices within this feature's address window
  localparam logic [7:0] IDX_SHADOW = 8'd0;
  localparam logic [7:0] IDX_ACTIVE = 8'd1;
  localparam logic [7:0] IDX_STATUS = 8'd2;

  // Decoded bus fields
  logic        hit;
  logic [7:0]  reg_idx;
  logic        shadow_wr;
  logic        commit_fire;
  logic        read_fire;

  // State
  logic [31:0] shadow_reg;
  logic [31:0] shadow_next;
  logic [31:0] active_reg;
  logic        pending_reg;
  logic        pending_next;
  logic [7:0]  commit_count_reg;
  logic [31:0] read_data_reg;
  logic        read_valid_reg;
  logic [31:0] read_mux;

  assign hit     = (config_addr[15:0] == TILE_ID) && (config_addr[31:24] == SB_FEATURE);
  assign reg_idx = config_addr[23:16];

  // A shadow write counts only when at least one byte lane is enabled; writes
  // to any other index are silently dropped.
  assign shadow_wr   = hit && config_write && (reg_idx == IDX_SHADOW) && (config_byte_en != 4'b0000);
  // The commit strobe is broadcast to every tile, so it is not address-qualified.
  assign commit_fire = config_commit && pending_reg;
  assign read_fire   = hit && config_read;

  // Per-byte merge of new write data into the shadow word
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign shadow_next[8*gi +: 8] = (shadow_wr && config_byte_en[gi])
                                      ? config_data[8*gi +: 8]
                                      : shadow_reg[8*gi +: 8];
    end
  endgenerate

  // Pending: a same-cycle write wins over the commit's clear, because the
  // commit moved the pre-write shadow and the new data is still uncommitted.
  always_comb begin
    pending_next = pending_reg;
    if (commit_fire) begin
      pending_next = 1'b0;
    end
    if (shadow_wr) begin
      pending_next = 1'b1;
    end
  end

  // Readback mux samples pre-edge state, so same-cycle writes/commits are not seen
  always_comb begin
    read_mux = 32'h0000_0000;
    case (reg_idx)
      IDX_SHADOW: read_mux = shadow_reg;
      IDX_ACTIVE: read_mux = active_reg;
      IDX_STATUS: read_mux = {23'h000000, pending_reg, commit_count_reg};
      default:    read_mux = 32'h0000_0000;
    endcase
  end

  // Shadow, active, pending and commit counter update
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_reg       <= 32'h0000_0000;
      active_reg       <= 32'h0000_0000;
      pending_reg      <= 1'b0;
      commit_count_reg <= 8'h00;
    end else begin
      shadow_reg  <= shadow_next;
      pending_reg <= pending_next;
      if (commit_fire) begin
        // Active takes the pre-write shadow even when a write lands this cycle
        active_reg       <= shadow_reg;
        commit_count_reg <= commit_count_reg + 8'd1;
      end
    end
  end

  // Registered readback: valid pulses one cycle per hit read, data holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_reg  <= 32'h0000_0000;
      read_valid_reg <= 1'b0;
    end else begin
      read_valid_reg <= read_fire;
      if (read_fire) begin
        read_data_reg <= read_mux;
      end
    end
  end

  assign config_sb      = active_reg;
  assign read_data      = read_data_reg;
  assign read_valid     = read_valid_reg;
  assign commit_pending = pending_reg;

endmodule

// File: tb/tb_sb_config_ctrl.sv
// Testbench for sb_config_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a behavioural model.
module tb_sb_config_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [3:0]  config_byte_en;
  logic        config_write;
  logic        config_read;
  logic        config_commit;
  logic [31:0] config_sb;
  logic [31:0] read_data;
  logic        read_valid;
  logic        commit_pending;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  logic [31:0] m_shadow, m_active, m_rdata;
  logic        m_pending, m_rvalid;
  logic [7:0]  m_count;

  sb_config_ctrl #(.TILE_ID(16'h0001), .SB_FEATURE(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .config_byte_en (config_byte_en),
    .config_write   (config_write),
    .config_read    (config_read),
    .config_commit  (config_commit),
    .config_sb      (config_sb),
    .read_data      (read_data),
    .read_valid     (read_valid),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
    logic        rd;
    logic        cm;
    logic [31:0] e_sb;
    logic        e_pend;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[23];

  function automatic logic [31:0] A(input logic [7:0] idx, input logic [15:0] tile = 16'h0001);
    return {8'h00, idx, tile};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: reads see pre-cycle state, commit moves the pre-write shadow,
  // then the write merges bytes and re-arms pending.
  task automatic model_update();
    logic hit;
    logic [7:0] idx;
    hit = (config_addr[15:0] == 16'h0001) && (config_addr[31:24] == 8'h00);
    idx = config_addr[23:16];
    if (reset) begin
      m_shadow = 0; m_active = 0; m_pending = 0; m_count = 0; m_rdata = 0; m_rvalid = 0;
      return;
    end
    m_rvalid = hit && config_read;
    if (m_rvalid) begin
      if (idx == 0)      m_rdata = m_shadow;
      else if (idx == 1) m_rdata = m_active;
      else if (idx == 2) m_rdata = {23'd0, m_pending, m_count};
      else               m_rdata = 0;
    end
    if (config_commit && m_pending) begin
      m_active  = m_shadow;
      m_count   = m_count + 8'd1;
      m_pending = 0;
    end
    if (hit && config_write && idx == 0 && config_byte_en != 0) begin
      for (int b = 0; b < 4; b++)
        if (config_byte_en[b]) m_shadow[8*b +: 8] = config_data[8*b +: 8];
      m_pending = 1;
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic wr, input logic rd, input logic cm,
                      input bit chk_model);
    reset = rst; config_addr = addr; config_data = data; config_byte_en = be;
    config_write = wr; config_read = rd; config_commit = cm;
    @(posedge clk);
    model_update();
    #1;
    if (chk_model) begin
      chk("model_sb", config_sb, m_active);
      chk("model_pending", {31'd0, commit_pending}, {31'd0, m_pending});
      chk("model_rvalid", {31'd0, read_valid}, {31'd0, m_rvalid});
      chk("model_rdata", read_data, m_rdata);
    end
  endtask

  task automatic idle(input bit chk_model);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, chk_model);
  endtask

  initial begin
    // Directed table; expected values worked out by hand from the register rules
    vt[0]  = '{A(0), 32'h00000C00, 4'hF, 1, 0, 0, 32'h00000000, 1, 0, 32'h0};
    vt[1]  = '{A(0), 32'h0,        4'h0, 0, 0, 1, 32'h00000C00, 0, 0, 32'h0};
    vt[2]  = '{A(2), 32'h0,        4'h0, 0, 1, 0, 32'h00000C00, 0, 1, 32'h1};
    vt[3]  = '{A(0, 16'h0002), 32'hFFFFFFFF, 4'hF, 1, 0, 1, 32'h00000C00, 0, 0, 32'h1};
    vt[4]  = '{A(2, 16'h0002), 32'h0, 4'h0, 0, 1, 0, 32'h00000C00, 0, 0, 32'h1};
    vt[5]  = '{A(2), 32'h0,        4'h0, 0, 1, 0, 32'h00000C00, 0, 1, 32'h1};
    vt[6]  = '{A(0), 32'hFFFFFFFF, 4'hF, 1, 0, 0, 32'h00000C00, 1, 0, 32'h1};
    vt[7]  = '{A(0), 32'h00000400, 4'h2, 1, 0, 0, 32'h00000C00, 1, 0, 32'h1};
    vt[8]  = '{A(0), 32'h0,        4'h0, 0, 1, 0, 32'h00000C00, 1, 1, 32'hFFFF04FF};
    vt[9]  = '{A(0), 32'h0,        4'h0, 0, 0, 1, 32'hFFFF04FF, 0, 0, 32'hFFFF04FF};
    vt[10] = '{A(0), 32'h00000400, 4'hF, 1, 0, 0, 32'hFFFF04FF, 1, 0, 32'hFFFF04FF};
    vt[11] = '{A(0), 32'h00000800, 4'hF, 1, 1, 1, 32'h00000400, 1, 1, 32'h00000400};
    vt[12] = '{A(2), 32'h0,        4'h0, 0, 1, 1, 32'h00000800, 0, 1, 32'h00000103};
    vt[13] = '{A(2), 32'h0,        4'h0, 0, 1, 0, 32'h00000800, 0, 1, 32'h00000004};
    vt[14] = '{A(0), 32'h00000123, 4'hF, 1, 1, 0, 32'h00000800, 1, 1, 32'h00000800};
    vt[15] = '{A(1), 32'h0,        4'h0, 0, 1, 0, 32'h00000800, 1, 1, 32'h00000800};
    vt[16] = '{A(7), 32'h0,        4'h0, 0, 1, 0, 32'h00000800, 1, 1, 32'h00000000};
    vt[17] = '{A(1), 32'hDEADBEEF, 4'hF, 1, 0, 0, 32'h00000800, 1, 0, 32'h00000000};
    vt[18] = '{A(0), 32'h0,        4'h0, 0, 1, 1, 32'h00000123, 0, 1, 32'h00000123};
    vt[19] = '{A(2), 32'h0,        4'h0, 0, 1, 0, 32'h00000123, 0, 1, 32'h00000005};
    vt[20] = '{A(0), 32'h0000FFFF, 4'h0, 1, 0, 0, 32'h00000123, 0, 0, 32'h00000005};
    vt[21] = '{32'h01020001, 32'h0, 4'h0, 0, 1, 0, 32'h00000123, 0, 0, 32'h00000005};
    vt[22] = '{A(0), 32'h0,        4'h0, 0, 1, 0, 32'h00000123, 0, 1, 32'h00000123};

    // Reset state
    step(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, A(0), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_sb", config_sb, 32'h0);
    chk("reset_pending", {31'd0, commit_pending}, 32'h0);
    chk("reset_rvalid", {31'd0, read_valid}, 32'h0);
    chk("reset_rdata", read_data, 32'h0);

    for (int i = 0; i < 23; i++) begin
      step(1'b0, vt[i].addr, vt[i].data, vt[i].be, vt[i].wr, vt[i].rd, vt[i].cm, 1'b0);
      chk($sformatf("vec%0d_sb", i), config_sb, vt[i].e_sb);
      chk($sformatf("vec%0d_pending", i), {31'd0, commit_pending}, {31'd0, vt[i].e_pend});
      chk($sformatf("vec%0d_rvalid", i), {31'd0, read_valid}, {31'd0, vt[i].e_rv});
      chk($sformatf("vec%0d_rdata", i), read_data, vt[i].e_rd);
      $display("vec %0d: sb=%h pend=%0d rv=%0d rd=%h", i, config_sb, commit_pending, read_valid, read_data);
    end

    // Commit counter wrap over 256 write+commit pairs
    step(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, A(0), i, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, A(0), 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    step(1'b0, A(2), 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap_status", read_data, 32'h0);
    chk("wrap_sb", config_sb, 32'd255);
    $display("wrap: status=%h sb=%h", read_data, config_sb);
    step(1'b0, A(7), 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("idx7_rvalid", {31'd0, read_valid}, 32'h1);
    chk("idx7_rdata", read_data, 32'h0);
    step(1'b0, A(0), 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, A(2), 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("noop_commit_status", read_data, 32'h0);
    $display("noop commit: status=%h", read_data);

    // Back-to-back reads give consecutive valid pulses, then valid drops
    for (int i = 0; i < 3; i++) begin
      step(1'b0, A(i[7:0]), 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("b2b_rvalid%0d", i), {31'd0, read_valid}, 32'h1);
    end
    idle(1'b1);
    chk("b2b_drop", {31'd0, read_valid}, 32'h0);
    chk("b2b_hold", read_data, 32'h00000000);
    $display("back-to-back reads: final rd=%h", read_data);

    // Reset in the same cycle as write, read and commit
    step(1'b0, A(0), 32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, A(0), 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, A(0), 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, A(0), 32'h12345678, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_sb", config_sb, 32'h0);
    chk("midrst_pending", {31'd0, commit_pending}, 32'h0);
    chk("midrst_rvalid", {31'd0, read_valid}, 32'h0);
    step(1'b0, A(0), 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("midrst_shadow", read_data, 32'h0);
    $display("mid-sequence reset: sb=%h shadow=%h", config_sb, read_data);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [7:0]  idx;
      int e0;
      idx = ($urandom_range(0, 9) == 0) ? 8'd7 : 8'($urandom_range(0, 2));
      a = A(idx);
      if ($urandom_range(0, 7) == 0) a[15:0] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) a[31:24] = 8'($urandom);
      e0 = n_err;
      step(($urandom_range(0, 199) == 0), a, $urandom, 4'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0), 1'b1);
      if (i % 500 == 0 || n_err != e0)
        $display("rand %0d: addr=%h sb=%h pend=%0d rv=%0d rd=%h", i, a, config_sb,
                 commit_pending, read_valid, read_data);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
